ethernet_mdio_controller: RTL and testbench

Clause-22 MDIO management controller for the board's RMII Ethernet PHY.
- Serialises host register read/write requests onto MDC/MDIO.
- Schedules periodic polls of PHY status register 1 (BMSR) to maintain a `link_up` flag.
- Sits beside the RMII MAC/FIFO wrapper in the same 50 MHz domain; the wrapper's MAC is not touched.

---
 rtl/ethernet_mdio_controller.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ethernet_mdio_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethernet_mdio_controller.sv
// -----------------------------------------------------------------------------
// ethernet_mdio_controller
//
// Clause-22 MDIO management master for the board's RMII PHY. Host register
// read/write requests are serialised onto MDC/MDIO. When enabled, periodic
// polls of the PHY status register (BMSR, reg 1) keep a link_up flag current.
// Everything runs in the 50 MHz clock50 domain on the rising edge.
//
// Handshake: a request is accepted in any cycle where req_valid && req_ready.
// req_valid may be raised at any time; request fields are captured on the
// acceptance edge, so the host may change them afterwards. The response is a
// single-cycle rsp_valid pulse with no back-pressure.
//
// Ports
//   clock50, resetn          clock and asynchronous active-low reset
//   req_valid/req_ready      host request handshake
//   req_write/req_reg/       request kind (1 = write), REGAD, write data
//   req_wdata
//   rsp_valid/rsp_rdata      completion pulse and read data (0 for writes)
//   poll_enable              enable periodic BMSR polling
//   link_up                  BMSR bit 2 from the last completed poll
//   busy                     frame in progress (host or poll)
//   mdc, mdio_o, mdio_oe     management clock, MDIO drive value and enable
//   mdio_i                   MDIO pad input
//   dbg_state_o              current FSM state
// -----------------------------------------------------------------------------
module ethernet_mdio_controller #(
  parameter int unsigned CLK_DIV       = 20,
  parameter logic [4:0]  PHY_ADDR      = 5'd1,
  parameter int unsigned POLL_INTERVAL = 500000
) (
  input  logic        clock50,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  input  logic        poll_enable,
  output logic        link_up,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  output logic [2:0]  dbg_state_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(POLL_INTERVAL + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE   = DW'(CLK_DIV - 2);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_CMD  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4,
    S_END  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          mdc_q, mdc_d;
  logic          mdio_o_q, mdio_o_d;
  logic          mdio_oe_q, mdio_oe_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_rdata_q, rsp_rdata_d;
  logic          link_up_q, link_up_d;
  logic          busy_q, busy_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic          poll_pending_q, poll_pending_d;
  logic          poll_en_q, poll_en_d;
  logic          write_q, write_d;
  logic          poll_q, poll_d;
  logic [4:0]    reg_q, reg_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;

  logic          half_end, bit_end, sample, finish;
  logic          start_host, start_poll;
  state_e        nst;
  logic [4:0]    ncnt;
  logic [13:0]   cmd_bits;

  // ST, OP, PHYAD, REGAD shifted out MSB-first during CMD.
  assign cmd_bits = {2'b01, (write_q ? 2'b01 : 2'b10), PHY_ADDR, reg_q};

  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    div_d          = div_q;
    mdc_d          = mdc_q;
    mdio_o_d       = mdio_o_q;
    mdio_oe_d      = mdio_oe_q;
    rsp_valid_d    = 1'b0;
    rsp_rdata_d    = rsp_rdata_q;
    link_up_d      = link_up_q;
    poll_cnt_d     = poll_cnt_q;
    poll_pending_d = poll_pending_q;
    poll_en_d      = poll_enable;
    write_d        = write_q;
    poll_d         = poll_q;
    reg_d          = reg_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    nst            = state_q;
    ncnt           = bit_cnt_q;

    half_end   = (div_q == DIV_LAST);
    bit_end    = mdc_q && half_end;
    // Read bits are taken in the last cycle of the MDC low half.
    sample     = !mdc_q && half_end && (state_q == S_DATA);
    // Completion is flagged one cycle early so the registered pulse lines up
    // with the END->IDLE cycle.
    finish     = (state_q == S_END) && mdc_q && (div_q == DIV_PRE);
    start_host = (state_q == S_IDLE) && req_ready_q && req_valid;
    start_poll = (state_q == S_IDLE) && req_ready_q && !req_valid && poll_pending_q;

    if (state_q == S_IDLE) begin
      if (start_host || start_poll) begin
        state_d   = S_PRE;
        bit_cnt_d = 5'd31;
        div_d     = '0;
        mdc_d     = 1'b0;
        mdio_o_d  = 1'b1;
        mdio_oe_d = 1'b1;
        rdata_d   = '0;
        write_d   = start_host && req_write;
        poll_d    = start_poll;
        reg_d     = start_host ? req_reg : 5'd1;
        wdata_d   = start_host ? req_wdata : 16'h0000;
      end
    end else begin
      div_d = half_end ? '0 : div_q + DW'(1);
      if (half_end) mdc_d = !mdc_q;
      if (sample) rdata_d = {rdata_q[14:0], mdio_i};
      if (finish) begin
        if (poll_q) begin
          link_up_d = rdata_q[2];
        end else begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? 16'h0000 : rdata_q;
        end
      end
      if (bit_end) begin
        if (bit_cnt_q != 5'd0) begin
          ncnt = bit_cnt_q - 5'd1;
        end else begin
          case (state_q)
            S_PRE:   begin nst = S_CMD;  ncnt = 5'd13; end
            S_CMD:   begin nst = S_TA;   ncnt = 5'd1;  end
            S_TA:    begin nst = S_DATA; ncnt = 5'd15; end
            S_DATA:  begin nst = S_END;  ncnt = 5'd0;  end
            default: begin nst = S_IDLE; ncnt = 5'd0;  end
          endcase
        end
        state_d   = nst;
        bit_cnt_d = ncnt;
        // New bit value is launched on the MDC falling edge.
        case (nst)
          S_PRE: begin
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b1;
          end
          S_CMD: begin
            mdio_o_d  = cmd_bits[ncnt[3:0]];
            mdio_oe_d = 1'b1;
          end
          S_TA: begin
            mdio_o_d  = write_q ? ncnt[0] : 1'b1;
            mdio_oe_d = write_q;
          end
          S_DATA: begin
            mdio_o_d  = write_q ? wdata_q[ncnt[3:0]] : 1'b1;
            mdio_oe_d = write_q;
          end
          default: begin
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b0;
          end
        endcase
      end
    end

    // Poll timer: the rising edge of poll_enable requests a poll at once.
    if (!poll_enable) begin
      poll_cnt_d     = '0;
      poll_pending_d = 1'b0;
    end else begin
      poll_pending_d = poll_pending_q && !start_poll;
      if (poll_cnt_q == POLL_LAST) begin
        poll_cnt_d     = '0;
        poll_pending_d = 1'b1;
      end else begin
        poll_cnt_d = poll_cnt_q + PW'(1);
      end
      if (!poll_en_q) poll_pending_d = 1'b1;
    end

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clock50 or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= '0;
      div_q          <= '0;
      mdc_q          <= 1'b0;
      mdio_o_q       <= 1'b1;
      mdio_oe_q      <= 1'b0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      link_up_q      <= 1'b0;
      busy_q         <= 1'b0;
      poll_cnt_q     <= '0;
      poll_pending_q <= 1'b0;
      poll_en_q      <= 1'b0;
      write_q        <= 1'b0;
      poll_q         <= 1'b0;
      reg_q          <= '0;
      wdata_q        <= '0;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      div_q          <= div_d;
      mdc_q          <= mdc_d;
      mdio_o_q       <= mdio_o_d;
      mdio_oe_q      <= mdio_oe_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      link_up_q      <= link_up_d;
      busy_q         <= busy_d;
      poll_cnt_q     <= poll_cnt_d;
      poll_pending_q <= poll_pending_d;
      poll_en_q      <= poll_en_d;
      write_q        <= write_d;
      poll_q         <= poll_d;
      reg_q          <= reg_d;
      wdata_q        <= wdata_d;
      rdata_q        <= rdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign link_up     = link_up_q;
  assign busy        = busy_q;
  assign mdc         = mdc_q;
  assign mdio_o      = mdio_o_q;
  assign mdio_oe     = mdio_oe_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ethernet_mdio_controller.sv
// -----------------------------------------------------------------------------
// Bench for ethernet_mdio_controller: write/read frames, back-to-back
// requests, BMSR polling, host/poll collision, mid-frame reset, and a second
// instance with CLK_DIV=2.
// -----------------------------------------------------------------------------
module tb_ethernet_mdio_controller;

  localparam int DIV   = 20;
  localparam int PI    = 6000;
  localparam int FRAME = 65 * 2 * DIV;
  localparam int EW    = 32 + 16 + 64 + 64;
  localparam logic [63:0] ALL1    = 64'hFFFFFFFF_FFFFFFFF;
  localparam logic [63:0] RD_MASK = 64'hFFFFFFFF_FFFC0000;

  // ---------------- clock / reset ----------------
  logic clock50 = 1'b0;
  always #5 clock50 = ~clock50;

  int cyc = 0;
  always @(posedge clock50) cyc <= cyc + 1;

  logic        resetn;
  logic        req_valid, req_write, poll_enable, mdio_i;
  logic [4:0]  req_reg;
  logic [15:0] req_wdata;
  logic        req_ready, rsp_valid, link_up, busy, mdc, mdio_o, mdio_oe;
  logic [15:0] rsp_rdata;
  logic [2:0]  dbg_state;

  logic        req_valid2, req_write2, poll_enable2, mdio_i2;
  logic [4:0]  req_reg2;
  logic [15:0] req_wdata2;
  logic        req_ready2, rsp_valid2, link_up2, busy2, mdc2, mdio_o2, mdio_oe2;
  logic [15:0] rsp_rdata2;
  logic [2:0]  dbg_state2;

  ethernet_mdio_controller #(.CLK_DIV(DIV), .PHY_ADDR(5'd1), .POLL_INTERVAL(PI)) u_dut (
    .clock50(clock50), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .poll_enable(poll_enable), .link_up(link_up), .busy(busy),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i),
    .dbg_state_o(dbg_state)
  );

  ethernet_mdio_controller #(.CLK_DIV(2), .PHY_ADDR(5'd1), .POLL_INTERVAL(1000)) u_dut2 (
    .clock50(clock50), .resetn(resetn),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write2),
    .req_reg(req_reg2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
    .poll_enable(poll_enable2), .link_up(link_up2), .busy(busy2),
    .mdc(mdc2), .mdio_o(mdio_o2), .mdio_oe(mdio_oe2), .mdio_i(mdio_i2),
    .dbg_state_o(dbg_state2)
  );

  // ---------------- counters / check helper ----------------
  int vectors = 0;
  int fails   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- PHY model ----------------
  // Logs the MDIO line at each MDC rise and returns phy_data on read data bits.
  logic [15:0] phy_data = 16'h0000;
  int          rise_n   = 0;
  logic        mdc_prev = 1'b0;
  logic [63:0] log_o, log_oe;
  logic        idle_o, idle_oe;

  initial mdio_i = 1'b1;

  always @(negedge clock50) begin
    if (!busy) begin
      rise_n = 0;
      mdio_i = 1'b1;
    end else if (mdc && !mdc_prev) begin
      rise_n = rise_n + 1;
      if (rise_n <= 64) begin
        log_o[64 - rise_n]  = mdio_o;
        log_oe[64 - rise_n] = mdio_oe;
      end else if (rise_n == 65) begin
        idle_o  = mdio_o;
        idle_oe = mdio_oe;
      end
      if (rise_n >= 48 && rise_n <= 63) mdio_i = phy_data[63 - rise_n];
      else mdio_i = 1'b1;
    end
    mdc_prev = mdc;
  end

  // ---------------- scoreboard ----------------
  // Entry: {completion cycle, rdata, expected frame bits, driven-bit mask}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  always @(negedge clock50) begin
    if (resetn && rsp_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid with rdata %h, expected none (cycle %0d)",
                 rsp_rdata, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_cycle", 64'(cyc), 64'(mon_e[175:144]));
        check("rsp_rdata", 64'(rsp_rdata), 64'(mon_e[143:128]));
        check("frame_bits", log_o & mon_e[63:0], mon_e[127:64] & mon_e[63:0]);
        check("frame_oe", log_oe, mon_e[63:0]);
        check("idle_oe", 64'(idle_oe), 64'd0);
        check("idle_o", 64'(idle_o), 64'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic wr, input logic [4:0] rg, input logic [15:0] wd,
                      input logic exp_en, input logic [15:0] exp_rd,
                      input logic [63:0] bits, input logic [63:0] mask, output int acc);
    req_valid = 1'b1;
    req_write = wr;
    req_reg   = rg;
    req_wdata = wd;
    acc       = -1;
    for (int i = 0; i < 6000; i++) begin
      if (req_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clock50);
    end
    if (acc < 0) begin
      vectors++;
      fails++;
      $display("FAIL accept_timeout: got no req_ready, expected acceptance (cycle %0d)", cyc);
      req_valid = 1'b0;
    end else begin
      if (exp_en) exp_q.push_back({32'(acc + FRAME), exp_rd, bits, mask});
      @(negedge clock50);
      // Scramble the fields: the DUT must use its captured copy.
      req_valid = 1'b0;
      req_write = ~wr;
      req_reg   = 5'($urandom_range(0, 31));
      req_wdata = 16'($urandom_range(0, 65535));
      check("busy_after_accept", 64'(busy), 64'd1);
      check("ready_after_accept", 64'(req_ready), 64'd0);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clock50);
    if (exp_q.size() != 0) begin
      vectors++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clock50);
    check("ready_after_rsp", 64'(req_ready), 64'd1);
    check("busy_after_rsp", 64'(busy), 64'd0);
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) @(negedge clock50);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a1, a2, e, r1, r2, got;
    logic [15:0] rd2;
    logic m2_prev;

    resetn       = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_reg      = '0;
    req_wdata    = '0;
    poll_enable  = 1'b0;
    req_valid2   = 1'b0;
    req_write2   = 1'b0;
    req_reg2     = '0;
    req_wdata2   = '0;
    poll_enable2 = 1'b0;
    mdio_i2      = 1'b1;

    repeat (3) @(negedge clock50);
    check("rst_mdc", 64'(mdc), 64'd0);
    check("rst_mdio_o", 64'(mdio_o), 64'd1);
    check("rst_mdio_oe", 64'(mdio_oe), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_link_up", 64'(link_up), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    resetn = 1'b1;
    @(negedge clock50);
    check("ready_after_release", 64'(req_ready), 64'd1);

    // Write reg 0 = 0x3100
    send(1'b1, 5'd0, 16'h3100, 1'b1, 16'h0000, 64'hFFFFFFFF_50823100, ALL1, a1);
    wait_drain();

    // Read reg 2, PHY returns 0x0007
    phy_data = 16'h0007;
    send(1'b0, 5'd2, 16'h0000, 1'b1, 16'h0007, 64'hFFFFFFFF_60880000, RD_MASK, a1);
    wait_drain();

    // Back-to-back: write reg 4 = 0xDEAD, then read reg 3 returning 0xA5C3
    phy_data = 16'hA5C3;
    send(1'b1, 5'd4, 16'hDEAD, 1'b1, 16'h0000, 64'hFFFFFFFF_5092DEAD, ALL1, a1);
    send(1'b0, 5'd3, 16'h0000, 1'b1, 16'hA5C3, 64'hFFFFFFFF_608C0000, RD_MASK, a2);
    check("b2b_accept_cycle", 64'(a2), 64'(a1 + FRAME + 1));
    wait_drain();

    // Poll: enable edge starts a BMSR read at once
    phy_data    = 16'h782D;
    poll_enable = 1'b1;
    e           = cyc;
    wait_cycle(e + 2);
    check("poll_busy", 64'(busy), 64'd1);
    check("poll_ready", 64'(req_ready), 64'd0);
    wait_cycle(e + FRAME);
    check("poll1_link_before", 64'(link_up), 64'd0);
    @(negedge clock50);
    check("poll1_link_after", 64'(link_up), 64'd1);
    phy_data = 16'h7809;
    wait_cycle(e + PI + FRAME - 1);
    check("poll2_link_before", 64'(link_up), 64'd1);
    @(negedge clock50);
    check("poll2_link_after", 64'(link_up), 64'd0);

    // Collision: host request in the same cycle the timer poll is pending
    phy_data = 16'h0004;
    wait_cycle(e + 2 * PI);
    send(1'b0, 5'd2, 16'h0000, 1'b1, 16'h0004, 64'hFFFFFFFF_60880000, RD_MASK, a1);
    check("collision_accept_cycle", 64'(a1), 64'(e + 2 * PI));
    wait_cycle(a1 + 2 * FRAME);
    check("collision_poll_before", 64'(link_up), 64'd0);
    @(negedge clock50);
    check("collision_poll_after", 64'(link_up), 64'd1);
    poll_enable = 1'b0;
    @(negedge clock50);

    // Reset in the middle of the DATA phase of a read
    phy_data = 16'h1234;
    send(1'b0, 5'd2, 16'h0000, 1'b0, 16'h0000, 64'd0, 64'd0, a1);
    wait_cycle(a1 + 2000);
    check("pre_abort_state", 64'(dbg_state), 64'd4);
    resetn = 1'b0;
    #1;
    check("abort_mdc", 64'(mdc), 64'd0);
    check("abort_mdio_oe", 64'(mdio_oe), 64'd0);
    check("abort_mdio_o", 64'(mdio_o), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    repeat (3) @(negedge clock50);
    resetn = 1'b1;
    @(negedge clock50);
    send(1'b0, 5'd3, 16'h0000, 1'b1, 16'h1234, 64'hFFFFFFFF_608C0000, RD_MASK, a1);
    wait_drain();

    // CLK_DIV=2 instance: read reg 2 with the bus pulled high
    req_valid2 = 1'b1;
    req_reg2   = 5'd2;
    a1         = -1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready2) begin
        a1 = cyc;
        break;
      end
      @(negedge clock50);
    end
    check("div2_accepted", 64'(a1 >= 0), 64'd1);
    @(negedge clock50);
    req_valid2 = 1'b0;
    r1 = -1;
    r2 = -1;
    got = -1;
    rd2 = '0;
    m2_prev = mdc2;
    for (int i = 0; i < 400; i++) begin
      if (mdc2 && !m2_prev) begin
        if (r1 < 0) r1 = cyc;
        else if (r2 < 0) r2 = cyc;
      end
      m2_prev = mdc2;
      if (rsp_valid2) begin
        got = cyc;
        rd2 = rsp_rdata2;
        break;
      end
      @(negedge clock50);
    end
    check("div2_mdc_period", 64'(r2 - r1), 64'd4);
    check("div2_done_cycle", 64'(got), 64'(a1 + 260));
    check("div2_rdata", 64'(rd2), 64'hFFFF);

    repeat (5) @(negedge clock50);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
